// File: rtl/spike_rate_encoder_if.sv
// Sample handshake bundle for spike_rate_encoder: a producer offers an
// intensity sample and the encoder signals when it can take it.
interface spike_rate_encoder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate-codes one fixed-point intensity sample into a WINDOW-long spike train
// using a first-order sigma-delta accumulator; reports spikes per window.
module spike_rate_encoder #(
  parameter int  WIDTH      = 16,
  parameter int  FRACTIONAL = 8,
  parameter int  WINDOW     = 16,
  localparam int CNT_W      = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_rate_encoder_if.slave  bus,
  input  logic                 enable,
  output logic                 spike_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     spike_count
);

  localparam int               AW        = FRACTIONAL + 1;
  localparam logic [AW-1:0]    ONE       = {1'b1, {FRACTIONAL{1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-AW){1'b0}}, ONE};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_r;
  logic [AW-1:0]    rate_r;
  logic [AW-1:0]    acc_r;
  logic [CNT_W-1:0] step_r;
  logic [AW-1:0]    sum_s;

  // Rates above 1.0 spike/timestep cannot be represented; clamp to ONE.
  function automatic logic [AW-1:0] sat_rate(input logic [WIDTH-1:0] value);
    if (value > ONE_W) begin
      return ONE;
    end else begin
      return value[AW-1:0];
    end
  endfunction

  // Accumulator candidate; acc < ONE and rate <= ONE keep it within AW bits.
  always_comb begin
    sum_s = acc_r + rate_r;
  end

  assign bus.in_ready = (state_r == ST_IDLE);
  assign busy         = (state_r == ST_RUN);

  // Encoder FSM with registered spike, done and count outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rate_r      <= '0;
      acc_r       <= '0;
      step_r      <= '0;
      spike_out   <= 1'b0;
      done        <= 1'b0;
      spike_count <= '0;
    end else begin
      spike_out <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_r     <= ST_RUN;
            rate_r      <= sat_rate(bus.in_value);
            acc_r       <= '0;
            step_r      <= '0;
            spike_count <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (enable) begin
            if (sum_s >= ONE) begin
              spike_out   <= 1'b1;
              acc_r       <= sum_s - ONE;
              spike_count <= spike_count + CNT_W'(1);
            end else begin
              acc_r <= sum_s;
            end
            step_r <= step_r + CNT_W'(1);
            // The edge processing the last timestep closes the window.
            if (step_r == LAST_STEP) begin
              state_r <= ST_IDLE;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
